multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//   Main control FSM for the multi-cycle variant of the ARM-subset processor.
//   Sequences one shared ALU, memory port and register file over FETCH/DECODE/EXECUTE/MEM/WB steps.
//   Decodes op/funct into ALU control and flag-write per step.
//   Sits between the instruction register and the datapath muxes; condition logic supplies cond_ex.
// PARAMETERS
//   PC_REG      4'd15   register index treated as PC (writes to it also assert pc_write)
//   STATE_W     4       width of state encoding / dbg_state port
// PORTS
//   clk         in   1   single clock; all state updates on rising edge
//   reset       in   1   synchronous, active-high
//   op          in   2   00 data-proc, 01 memory, 10 branch, 11 illegal
//   funct       in   6   [5]=I (immediate), [4:1]=cmd, [0]=S (data-proc) / L (memory)
//   rd          in   4   destination register index
//   cond_ex     in   1   instruction condition passed (from condition logic)
//   mem_ready   in   1   memory completes access this cycle
//   pc_write    out  1   PC load strobe
//   ir_write    out  1   instruction register load strobe
//   mem_write   out  1   data memory write strobe
//   reg_write   out  1   register file write strobe
//   adr_src     out  1   0=PC, 1=ALUOut to memory address
//   alu_src_a   out  2   00 reg A, 01 PC, 10 ALUOut
//   alu_src_b   out  2   00 reg B, 01 extended imm, 10 const 4
//   result_src  out  2   00 ALUOut, 01 read data, 10 ALU result direct
//   alu_control out  4   ALU op: ADD 0000, SUB 0001, MOV 0010, AND 0100, ORR 0101, invalid 1010
//   flag_w      out  2   [1]=NZ write, [0]=CV write
//   dbg_state   out  4   current state encoding
// BEHAVIOUR
//   - States (enc): FETCH 0, DECODE 1, EXECR 2, EXECI 3, ALUWB 4, MEMADR 5, MEMRD 6, MEMWB 7, MEMWR 8, BRANCH 9.
//     Codes 10-15 are unreachable and return to FETCH.
//   - Outputs are Moore/decode-combinational; any output not listed for a state is 0.
//   - reset=1: state<=FETCH next edge; while reset high, all strobes (pc_write, ir_write, mem_write, reg_write, flag_w) are 0.
//     Reset mid-instruction abandons it; no writes occur.
//   - FETCH: adr_src=0, src_a=01, src_b=10, ADD, result_src=10.
//     Holds while !mem_ready; pc_write=ir_write=1 only in the mem_ready cycle, then ->DECODE.
//   - DECODE: src_a=01, src_b=10, ADD (PC+8 into ALUOut).
//     op00&!I->EXECR, op00&I->EXECI, op01->MEMADR, op10->BRANCH, op11->FETCH (no writes).
//   - EXECR/EXECI: src_a=00, src_b=00/01, alu_control/flag_w from cmd table; flag_w gated by cond_ex. ->ALUWB.
//   - cmd table: 0100 ADD, 0010 SUB (S: flag_w=11); 0000 AND, 1100 ORR, 1101 MOV (S: flag_w=10).
//     Other cmd: alu_control=1010, flag_w=00, ALUWB reg_write forced 0.
//   - ALUWB: result_src=00, reg_write=cond_ex; pc_write=cond_ex if rd==PC_REG. ->FETCH.
//   - MEMADR: src_a=00, src_b=01, ADD. L=1->MEMRD, L=0->MEMWR.
//   - MEMRD: adr_src=1; hold until mem_ready, then ->MEMWB.
//   - MEMWB: result_src=01, reg_write=cond_ex; pc_write if rd==PC_REG. ->FETCH.
//   - MEMWR: adr_src=1, mem_write=cond_ex held every cycle until mem_ready. ->FETCH.
//   - BRANCH: src_a=10, src_b=01, ADD, result_src=10, pc_write=cond_ex. ->FETCH.
//   - Latency with mem_ready=1 always: data-proc 4, LDR 5, STR 4, B 3 cycles.
//     Each wait cycle adds 1; no timeout.
//   - cond_ex=0: sequence runs unchanged; only write strobes and flag_w are suppressed.
// CONFIGURATION
//   MULTICYCLE_CTRL_CMP_EN defined: cmd 1010 (CMP) decodes to SUB with flag_w=11 (gated by cond_ex) regardless of S.
//     EXECR/EXECI then go directly to FETCH (3 cycles, no writeback).
//   Undefined: cmd 1010 is invalid (alu_control=1010, no flag or register write, 4 cycles).
// TESTING
//   - reset 3 cycles mid-MEMWR -> strobes 0 during reset; dbg_state=0 after; no mem_write once reset asserted.
//   - ADD S, rd=3, cond_ex=1, mem_ready=1 -> states 0,1,2,4; EXECR alu_control=0000, flag_w=11; ALUWB reg_write=1, pc_write=0.
//   - LDR rd=15, mem_ready low 2 cycles in MEMRD -> states 0,1,5,6,6,6,7; MEMWB reg_write=1, pc_write=1.
//   - STR cond_ex=0 -> sequence 0,1,5,8; mem_write=0 throughout.
//   - B cond_ex=1 -> 0,1,9; BRANCH pc_write=1, src_a=10, src_b=01.
//   - cmd 1010 S=1: with CMP_EN -> alu_control=0001, flag_w=11, 0,1,2,0; without -> 1010, flag_w=00, reg_write=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle ARM-subset processor.
// Sequences the shared ALU, memory port and register file through
// FETCH/DECODE/EXECUTE/MEM/WB steps and decodes op/funct into ALU control.
// Outputs are decoded from the current state and the held instruction fields
// within the same cycle, so the datapath muxes see them without delay.
// Build option: define MULTICYCLE_CTRL_CMP_EN to decode cmd 1010 as CMP
// (SUB with NZCV flag write and no register writeback).
module multicycle_control_fsm #(
    parameter logic [3:0]  PC_REG  = 4'd15,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic               cond_ex,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               adr_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [3:0]         alu_control,
    output logic [1:0]         flag_w,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int unsigned ALU_W  = 4;
    localparam int unsigned FLAG_W = 2;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_MOV = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_ORR = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_BAD = 4'b1010;

    // Data-processing command field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
`ifdef MULTICYCLE_CTRL_CMP_EN
    localparam logic [3:0] CMD_CMP = 4'b1010;
`endif

    // Flag write enables: [1]=NZ, [0]=CV
    localparam logic [FLAG_W-1:0] FLAG_NONE = 2'b00;
    localparam logic [FLAG_W-1:0] FLAG_NZ   = 2'b10;
    localparam logic [FLAG_W-1:0] FLAG_ALL  = 2'b11;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_REG    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_ALUOUT = 2'b10;
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_DATA     = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;

    // Instruction class encodings on op
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_EXECR  = STATE_W'(2),
        S_EXECI  = STATE_W'(3),
        S_ALUWB  = STATE_W'(4),
        S_MEMADR = STATE_W'(5),
        S_MEMRD  = STATE_W'(6),
        S_MEMWB  = STATE_W'(7),
        S_MEMWR  = STATE_W'(8),
        S_BRANCH = STATE_W'(9)
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0] cmd;
    logic       imm_bit;
    logic       s_bit;
    logic       pc_dest;

    logic [ALU_W-1:0]  cmd_alu;
    logic [FLAG_W-1:0] cmd_flags;
    logic              cmd_valid;
    logic              cmd_cmp;

    logic              pc_w_raw;
    logic              ir_w_raw;
    logic              mem_w_raw;
    logic              reg_w_raw;
    logic [FLAG_W-1:0] fw_raw;

    // Instruction field views; funct[0] is S for data-proc and L for memory
    assign cmd     = funct[4:1];
    assign imm_bit = funct[5];
    assign s_bit   = funct[0];
    assign pc_dest = (rd == PC_REG);

    // Data-processing command decode, shared by the execute and writeback steps
    always_comb begin
        cmd_alu   = ALU_BAD;
        cmd_flags = FLAG_NONE;
        cmd_valid = 1'b0;
        cmd_cmp   = 1'b0;
        case (cmd)
            CMD_ADD: begin
                cmd_alu   = ALU_ADD;
                cmd_flags = s_bit ? FLAG_ALL : FLAG_NONE;
                cmd_valid = 1'b1;
            end
            CMD_SUB: begin
                cmd_alu   = ALU_SUB;
                cmd_flags = s_bit ? FLAG_ALL : FLAG_NONE;
                cmd_valid = 1'b1;
            end
            CMD_AND: begin
                cmd_alu   = ALU_AND;
                cmd_flags = s_bit ? FLAG_NZ : FLAG_NONE;
                cmd_valid = 1'b1;
            end
            CMD_ORR: begin
                cmd_alu   = ALU_ORR;
                cmd_flags = s_bit ? FLAG_NZ : FLAG_NONE;
                cmd_valid = 1'b1;
            end
            CMD_MOV: begin
                cmd_alu   = ALU_MOV;
                cmd_flags = s_bit ? FLAG_NZ : FLAG_NONE;
                cmd_valid = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_CMP_EN
            CMD_CMP: begin
                cmd_alu   = ALU_SUB;
                cmd_flags = FLAG_ALL;
                cmd_valid = 1'b1;
                cmd_cmp   = 1'b1;
            end
`endif
            default: begin
                cmd_alu   = ALU_BAD;
                cmd_flags = FLAG_NONE;
                cmd_valid = 1'b0;
            end
        endcase
    end

    // State register; a synchronous reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing, including memory wait holds
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_DP:   state_next = imm_bit ? S_EXECI : S_EXECR;
                    OP_MEM:  state_next = S_MEMADR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_EXECR,
            S_EXECI:  state_next = cmd_cmp ? S_FETCH : S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_MEMADR: state_next = s_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_BRANCH: state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls and ungated write strobes
    always_comb begin
        pc_w_raw    = 1'b0;
        ir_w_raw    = 1'b0;
        mem_w_raw   = 1'b0;
        reg_w_raw   = 1'b0;
        fw_raw      = FLAG_NONE;
        adr_src     = 1'b0;
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_REG;
        result_src  = RES_ALUOUT;
        alu_control = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                pc_w_raw   = mem_ready;
                ir_w_raw   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
            end
            S_EXECR: begin
                alu_control = cmd_alu;
                fw_raw      = cond_ex ? cmd_flags : FLAG_NONE;
            end
            S_EXECI: begin
                alu_src_b   = SRC_B_IMM;
                alu_control = cmd_alu;
                fw_raw      = cond_ex ? cmd_flags : FLAG_NONE;
            end
            S_ALUWB: begin
                reg_w_raw = cond_ex & cmd_valid;
                pc_w_raw  = cond_ex & cmd_valid & pc_dest;
            end
            S_MEMADR: begin
                alu_src_b = SRC_B_IMM;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w_raw  = cond_ex;
                pc_w_raw   = cond_ex & pc_dest;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_w_raw = cond_ex;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_ALUOUT;
                alu_src_b  = SRC_B_IMM;
                result_src = RES_ALU;
                pc_w_raw   = cond_ex;
            end
            default: begin
                adr_src = 1'b0;
            end
        endcase
    end

    // No architectural write may escape while reset is held
    assign pc_write  = pc_w_raw  & ~reset;
    assign ir_write  = ir_w_raw  & ~reset;
    assign mem_write = mem_w_raw & ~reset;
    assign reg_write = reg_w_raw & ~reset;
    assign flag_w    = reset ? FLAG_NONE : fw_raw;
    assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Expected per-cycle outputs come from an instruction-level model that expands
// each instruction into its step sequence. Honours MULTICYCLE_CTRL_CMP_EN.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, flag_w;
    logic [3:0] alu_control;
    logic [3:0] dbg_state;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_w;
        logic       ir_w;
        logic       mem_w;
        logic       reg_w;
        logic       adr;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [1:0] fw;
    } obs_t;

    obs_t got;
    obs_t exp_q[$];
    bit   mr_q[$];
    bit   rand_mr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .rd          (rd),
        .cond_ex     (cond_ex),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .dbg_state   (dbg_state)
    );

    assign got = {dbg_state, pc_write, ir_write, mem_write, reg_write, adr_src,
                  alu_src_a, alu_src_b, result_src, alu_control, flag_w};

    // ALU op and flag class for a data-processing command
    function automatic void cmd_info(input logic [3:0] cmd, input logic s,
                                     output logic [3:0] alu, output logic [1:0] fw,
                                     output bit valid, output bit cmp);
        valid = 1'b1;
        cmp   = 1'b0;
        case (cmd)
            4'b0100: begin alu = 4'b0000; fw = s ? 2'b11 : 2'b00; end
            4'b0010: begin alu = 4'b0001; fw = s ? 2'b11 : 2'b00; end
            4'b0000: begin alu = 4'b0100; fw = s ? 2'b10 : 2'b00; end
            4'b1100: begin alu = 4'b0101; fw = s ? 2'b10 : 2'b00; end
            4'b1101: begin alu = 4'b0010; fw = s ? 2'b10 : 2'b00; end
`ifdef MULTICYCLE_CTRL_CMP_EN
            4'b1010: begin alu = 4'b0001; fw = 2'b11; cmp = 1'b1; end
`endif
            default: begin alu = 4'b1010; fw = 2'b00; valid = 1'b0; end
        endcase
    endfunction

    function automatic bit any_mr();
        return rand_mr ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic add(input obs_t e, input bit mr);
        exp_q.push_back(e);
        mr_q.push_back(mr);
    endtask

    // Expand one instruction into its expected cycle-by-cycle trace
    task automatic build(input logic [1:0] i_op, input logic [5:0] i_funct,
                         input logic [3:0] i_rd, input logic i_cond,
                         input int fetch_wait, input int mem_wait);
        obs_t e;
        logic [3:0] alu;
        logic [1:0] fw;
        bit valid, cmp;
        for (int i = 0; i <= fetch_wait; i++) begin
            e = '0; e.st = 4'd0; e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10;
            if (i == fetch_wait) begin e.pc_w = 1'b1; e.ir_w = 1'b1; end
            add(e, i == fetch_wait);
        end
        e = '0; e.st = 4'd1; e.sa = 2'b01; e.sb = 2'b10;
        add(e, any_mr());
        case (i_op)
            2'b00: begin
                cmd_info(i_funct[4:1], i_funct[0], alu, fw, valid, cmp);
                e = '0;
                e.st  = i_funct[5] ? 4'd3 : 4'd2;
                e.sb  = i_funct[5] ? 2'b01 : 2'b00;
                e.alu = alu;
                e.fw  = i_cond ? fw : 2'b00;
                add(e, any_mr());
                if (!cmp) begin
                    e = '0; e.st = 4'd4;
                    e.reg_w = valid && i_cond;
                    e.pc_w  = valid && i_cond && (i_rd == 4'd15);
                    add(e, any_mr());
                end
            end
            2'b01: begin
                e = '0; e.st = 4'd5; e.sb = 2'b01;
                add(e, any_mr());
                for (int i = 0; i <= mem_wait; i++) begin
                    e = '0; e.adr = 1'b1;
                    if (i_funct[0]) e.st = 4'd6;
                    else begin e.st = 4'd8; e.mem_w = i_cond; end
                    add(e, i == mem_wait);
                end
                if (i_funct[0]) begin
                    e = '0; e.st = 4'd7; e.rs = 2'b01;
                    e.reg_w = i_cond;
                    e.pc_w  = i_cond && (i_rd == 4'd15);
                    add(e, any_mr());
                end
            end
            2'b10: begin
                e = '0; e.st = 4'd9; e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10;
                e.pc_w = i_cond;
                add(e, any_mr());
            end
            default: ;
        endcase
    endtask

    task automatic check_obs(input string tag, input obs_t e);
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, e);
        end
    endtask

    // Drive queued cycles (at most max_n), comparing on the falling edge
    task automatic run_trace(input string tag, input int max_n);
        obs_t e;
        int n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            e = exp_q.pop_front();
            mem_ready = mr_q.pop_front();
            @(negedge clk);
            check_obs(tag, e);
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_instr(input string tag, input logic [1:0] i_op,
                             input logic [5:0] i_funct, input logic [3:0] i_rd,
                             input logic i_cond, input int fetch_wait, input int mem_wait);
        op = i_op; funct = i_funct; rd = i_rd; cond_ex = i_cond;
        build(i_op, i_funct, i_rd, i_cond, fetch_wait, mem_wait);
        run_trace(tag, 1000);
    endtask

    task automatic check_strobes_off(input string tag);
        logic [5:0] s;
        s = {pc_write, ir_write, mem_write, reg_write, flag_w};
        checks++;
        assert (s === 6'b0) else begin
            errors++;
            $error("FAIL %s observed=%b expected=000000", tag, s);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] exp_st);
        checks++;
        assert (dbg_state === exp_st) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp_st);
        end
    endtask

    initial begin
        logic [1:0] r_op;
        logic [5:0] r_funct;
        logic [3:0] r_rd;

        rand_mr = 1'b0;
        reset = 1'b1; op = 2'b00; funct = 6'b0; rd = 4'd0; cond_ex = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); check_strobes_off("reset_hold");
        @(posedge clk); #1;
        mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk); check_state("reset_state", 4'd0);
        @(posedge clk); #1;

        // ADD S rd=3: 0,1,2,4
        run_instr("add_s", 2'b00, 6'b0_0100_1, 4'd3, 1'b1, 0, 0);
        // LDR rd=15 with two memory wait cycles: 0,1,5,6,6,6,7
        run_instr("ldr_pc", 2'b01, 6'b1_1100_1, 4'd15, 1'b1, 0, 2);
        // STR with failed condition: 0,1,5,8 and no mem_write
        run_instr("str_nocond", 2'b01, 6'b1_1100_0, 4'd2, 1'b0, 0, 0);
        // Taken branch: 0,1,9
        run_instr("branch", 2'b10, 6'b10_0000, 4'd0, 1'b1, 0, 0);
        // cmd 1010 with S set (CMP or invalid, depending on build)
        run_instr("cmd1010", 2'b00, 6'b0_1010_1, 4'd5, 1'b1, 0, 0);
        // Illegal op returns to FETCH with no writes
        run_instr("illegal_op", 2'b11, 6'b0_0100_1, 4'd15, 1'b1, 1, 0);
        // Invalid command into PC: no writes
        run_instr("invalid_pc", 2'b00, 6'b1_0111_1, 4'd15, 1'b1, 0, 0);
        // ALU write to PC
        run_instr("mov_pc", 2'b00, 6'b1_1101_0, 4'd15, 1'b1, 2, 0);

        // Randomized instruction stream
        rand_mr = 1'b1;
        for (int k = 0; k < 150; k++) begin
            r_op    = 2'($urandom_range(0, 3));
            r_funct = 6'($urandom_range(0, 63));
            r_rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_instr("random", r_op, r_funct, r_rd, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end
        rand_mr = 1'b0;

        // Reset asserted for 3 cycles while a store is waiting in MEMWR
        op = 2'b01; funct = 6'b1_1100_0; rd = 4'd1; cond_ex = 1'b1;
        build(2'b01, 6'b1_1100_0, 4'd1, 1'b1, 0, 5);
        run_trace("str_pre_reset", 4);
        exp_q.delete();
        mr_q.delete();
        mem_ready = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check_strobes_off("reset_memwr");
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check_state("post_reset_state", 4'd0);
        check_strobes_off("post_reset_strobes");
        @(posedge clk); #1;
        run_instr("after_reset_b", 2'b10, 6'b10_0000, 4'd0, 1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
